deq_serializer: RTL and testbench
=================================

DEQ_SERIALIZER -- requirements
Module: deq_serializer

Interface
REQ-001 Parameter WIDTH, default 32: FIFO word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NBYTE, default 4: bytes per word; SHALL equal WIDTH/8.
REQ-003 Parameter W_IDX, default 2: byte-index width; SHALL satisfy 2**W_IDX >= NBYTE.
REQ-004 Parameter W_WCNT, default 16: word-counter width.
REQ-005 CLK  input  1  single clock, all state on rising edge.
REQ-006 RST_X  input  1  reset, asynchronous assert, active-low.
REQ-007 EMPTY  input  1  upstream FIFO empty flag.
REQ-008 DEQ  output  1  dequeue request to upstream FIFO.
REQ-009 DIN  input  WIDTH  upstream FIFO registered read data, valid the cycle after DEQ.
REQ-010 BOUT  output  8  serialized byte.
REQ-011 BVALID  output  1  BOUT holds a valid byte.
REQ-012 BREADY  input  1  downstream accepts BOUT this cycle.
REQ-013 BUSY  output  1  high in any state other than IDLE.
REQ-014 WCNT  output  W_WCNT  count of words fully transmitted, wraps modulo 2**W_WCNT.

Function
REQ-015 FSM states: IDLE, FETCH, SEND.
REQ-016 IDLE: DEQ = !EMPTY; if !EMPTY, next state FETCH, else stay in IDLE.
REQ-017 FETCH: DEQ low; DIN latched into a WIDTH-bit shift register; byte index cleared to 0; next state SEND.
REQ-018 SEND: BVALID high; BOUT = shift register bits [7:0], least-significant byte first.
REQ-019 Byte handshake completes on a cycle with BVALID && BREADY; on completion the shift register shifts right by 8 and the byte index increments.
REQ-020 With BREADY low, BOUT, BVALID and all state SHALL hold unchanged, with no limit on stall length.
REQ-021 Last-byte completion (index == NBYTE-1, BVALID && BREADY): WCNT increments by 1.
REQ-022 Last-byte completion with !EMPTY: DEQ asserted in the same cycle; next state FETCH (back-to-back; one word per NBYTE+1 cycles at full rate).
REQ-023 Last-byte completion with EMPTY: next state IDLE.
REQ-024 DEQ SHALL be combinational from state, byte index, BREADY and EMPTY, and never asserted while EMPTY is high.
REQ-025 DEQ SHALL be gated low whenever RST_X is low.
REQ-026 At most one DEQ per word: DEQ SHALL never be asserted in FETCH or in SEND before last-byte completion.
REQ-027 BVALID low in IDLE and FETCH; BOUT driven 0 whenever BVALID is low.
REQ-028 BUSY = (state != IDLE).
REQ-029 Byte index arithmetic is W_IDX bits and reset to 0 each FETCH; no wrap beyond NBYTE-1.

Reset
REQ-030 RST_X low forces, asynchronously: state IDLE, shift register 0, byte index 0, WCNT 0, BOUT 0, BVALID 0, DEQ 0, BUSY 0.
REQ-031 Reset asserted mid-word discards the in-flight word without incrementing WCNT.
REQ-032 Operation resumes from IDLE on the first rising edge after RST_X goes high.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding (IDLE=0, FETCH=1, SEND=2, 2-bit) and the byte width constant 8.
REQ-034 Single flat module; no sub-module; instantiated directly downstream of FIFO with DIN tied to FIFO DOUT and DEQ tied to FIFO DEQ.

Verification
REQ-035 Single word: push 0x44332211 into FIFO, BREADY=1 -> BOUT sequence 0x11,0x22,0x33,0x44 on 4 consecutive cycles; WCNT=1; return to IDLE; exactly one DEQ pulse.
REQ-036 Back-to-back: FIFO holds 0xA3A2A1A0, 0xB3B2B1B0, BREADY=1 -> 8 bytes in order; second DEQ coincides with the 0xA3 handshake; one FETCH gap cycle; WCNT=2.
REQ-037 Stall: BREADY low for 7 cycles while 0x22 is presented -> BOUT stays 0x22 with BVALID high; no DEQ; resumes 0x33 after BREADY rises.
REQ-038 Empty boundary: FIFO empty for 10 cycles -> DEQ never asserted, BUSY=0, BVALID=0.
REQ-039 Mid-word reset: pulse RST_X low after the 2nd byte of 0x44332211 -> BVALID=0 immediately, WCNT=0, next pushed word 0x0000BEEF emits 0xEF,0xBE,0x00,0x00.
REQ-040 Full-rate stream: 5 words with FIFO DEPTH=5 and random BREADY -> byte order preserved, WCNT=5, zero DEQ while EMPTY.

Source files
------------

// File: rtl/deq_serializer_pkg.sv
// ============================================================================
// Module   : deq_serializer_pkg
// Purpose  : Shared FSM encoding and byte-width constant for deq_serializer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package deq_serializer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/deq_serializer.sv
// ============================================================================
// Module   : deq_serializer
// Purpose  : Dequeues words from an upstream FIFO and emits them LSB-byte
//            first over a valid/ready byte stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module deq_serializer
  import deq_serializer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NBYTE  = 4,
  parameter int W_IDX  = 2,
  parameter int W_WCNT = 16
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              EMPTY,
  output logic              DEQ,
  input  logic [WIDTH-1:0]  DIN,
  output logic [7:0]        BOUT,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              BUSY,
  output logic [W_WCNT-1:0] WCNT
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_shift;
  logic [W_IDX-1:0]    r_idx;
  logic [W_WCNT-1:0]   r_wcnt;
  logic                w_send;
  logic                w_hs;
  logic                w_last;
  logic                w_deq;

  assign w_send = (r_state == ST_SEND);
  assign w_hs   = w_send && BREADY;
  assign w_last = w_hs && (r_idx == W_IDX'(NBYTE - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!EMPTY) begin
          w_deq       = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: w_state_nxt = ST_SEND;
      ST_SEND: begin
        // Fetch the next word in the same cycle as the last byte so a
        // streaming FIFO only costs one FETCH gap per word.
        if (w_last) begin
          if (!EMPTY) begin
            w_deq       = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // DEQ is combinational, so it must also be gated by the raw reset.
  assign DEQ    = w_deq && RST_X;
  assign BVALID = w_send;
  assign BOUT   = w_send ? r_shift[BYTE_W-1:0] : 8'h00;
  assign BUSY   = (r_state != ST_IDLE);
  assign WCNT   = r_wcnt;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FETCH) begin
        r_shift <= DIN;
        r_idx   <= '0;
      end else if (w_hs) begin
        r_shift <= r_shift >> BYTE_W;
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_last) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_deq_serializer.sv
// ============================================================================
// Module   : tb_deq_serializer
// Purpose  : Self-checking bench: FIFO model plus byte-stream scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_deq_serializer;

  logic        CLK    = 1'b0;
  logic        RST_X  = 1'b0;
  logic        EMPTY  = 1'b1;
  logic        BREADY = 1'b0;
  logic [31:0] DIN    = '0;
  logic        DEQ;
  logic [7:0]  BOUT;
  logic        BVALID;
  logic        BUSY;
  logic [15:0] WCNT;

  deq_serializer #(
    .WIDTH  (32),
    .NBYTE  (4),
    .W_IDX  (2),
    .W_WCNT (16)
  ) dut (
    .CLK    (CLK),
    .RST_X  (RST_X),
    .EMPTY  (EMPTY),
    .DEQ    (DEQ),
    .DIN    (DIN),
    .BOUT   (BOUT),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .BUSY   (BUSY),
    .WCNT   (WCNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] fifo_q[$];
  exp_t        exp_q[$];
  int          wcnt_exp  = 0;
  int          deq_cnt   = 0;
  int          acc_cnt   = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_bout  = '0;
  logic        s_deq, s_bvalid, s_busy;
  logic [7:0]  s_bout;

  bit bv1[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
  bit bv2[12] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample/score, then let the FIFO model
  // present read data one cycle after an accepted DEQ.
  task automatic cycle(input bit rdy);
    bit          fire;
    bit          last_pop;
    exp_t        e;
    logic [31:0] w;
    @(negedge CLK);
    BREADY = rdy;
    EMPTY  = (fifo_q.size() == 0);
    #1;
    s_deq = DEQ; s_bvalid = BVALID; s_bout = BOUT; s_busy = BUSY;
    check_eq("deq_while_empty", 32'(DEQ & EMPTY), 32'd0);
    check_eq("wcnt", 32'(WCNT), 32'(wcnt_exp[15:0]));
    if (!BVALID) check_eq("bout_idle", 32'(BOUT), 32'd0);
    else if (prev_stall) check_eq("bout_hold", 32'(BOUT), 32'(prev_bout));
    last_pop = 1'b0;
    if (BVALID && BREADY) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_byte", 32'(BVALID), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("byte", 32'(BOUT), 32'(e.b));
        last_pop = e.last;
        acc_cnt++;
      end
    end
    prev_stall = BVALID && !BREADY;
    prev_bout  = BOUT;
    fire = DEQ && (fifo_q.size() != 0);
    if (DEQ) deq_cnt++;
    @(posedge CLK);
    #1;
    if (last_pop) wcnt_exp++;
    if (fire) begin
      w   = fifo_q.pop_front();
      DIN = w;
      for (int i = 0; i < 4; i++) exp_q.push_back('{w[8*i +: 8], (i == 3)});
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_X  = 1'b0;
    BREADY = 1'b1;
    EMPTY  = (fifo_q.size() == 0);
    #1;
    check_eq("rst_deq",    32'(DEQ),    32'd0);
    check_eq("rst_bvalid", 32'(BVALID), 32'd0);
    check_eq("rst_bout",   32'(BOUT),   32'd0);
    check_eq("rst_busy",   32'(BUSY),   32'd0);
    check_eq("rst_wcnt",   32'(WCNT),   32'd0);
    exp_q.delete();
    wcnt_exp   = 0;
    prev_stall = 1'b0;
    @(posedge CLK);
    #1;
    RST_X = 1'b1;
  endtask

  initial begin
    int dc0, acc0, pushed;
    bit done;

    // Single word, full rate, with the word already waiting during reset.
    fifo_q.push_back(32'h44332211);
    do_reset();
    dc0 = deq_cnt;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1);
      check_eq("t1_bvalid", 32'(s_bvalid), 32'(bv1[i]));
      check_eq("t1_deq", 32'(s_deq), 32'(i == 0));
    end
    check_eq("t1_deq_count", 32'(deq_cnt - dc0), 32'd1);
    check_eq("t1_wcnt", 32'(WCNT), 32'd1);
    check_eq("t1_busy", 32'(s_busy), 32'd0);

    // Back-to-back words with a single FETCH gap.
    fifo_q.push_back(32'hA3A2A1A0);
    fifo_q.push_back(32'hB3B2B1B0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1);
      check_eq("t2_bvalid", 32'(s_bvalid), 32'(bv2[i]));
      check_eq("t2_deq", 32'(s_deq), 32'((i == 0) || (i == 5)));
      if (i == 5) check_eq("t2_deq_on_a3", 32'(s_bout), 32'hA3);
    end
    check_eq("t2_wcnt", 32'(WCNT), 32'd2);

    // Seven-cycle stall on the second byte.
    fifo_q.push_back(32'h44332211);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0);
      check_eq("t3_stall_bout", 32'(s_bout), 32'h22);
      check_eq("t3_stall_bvalid", 32'(s_bvalid), 32'd1);
      check_eq("t3_stall_deq", 32'(s_deq), 32'd0);
    end
    cycle(1'b1);
    check_eq("t3_release_bout", 32'(s_bout), 32'h22);
    cycle(1'b1);
    check_eq("t3_resume_bout", 32'(s_bout), 32'h33);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    check_eq("t3_wcnt", 32'(WCNT), 32'd1);

    // Empty FIFO: nothing may start.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(0, 1)));
      check_eq("t4_deq", 32'(s_deq), 32'd0);
      check_eq("t4_busy", 32'(s_busy), 32'd0);
      check_eq("t4_bvalid", 32'(s_bvalid), 32'd0);
    end

    // Asynchronous reset after the second byte, then a fresh word.
    fifo_q.push_back(32'h44332211);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1);
    check_eq("t5_pre_bvalid", 32'(BVALID), 32'd1);
    #2;
    RST_X = 1'b0;
    #1;
    check_eq("t5_async_bvalid", 32'(BVALID), 32'd0);
    check_eq("t5_async_bout", 32'(BOUT), 32'd0);
    check_eq("t5_async_busy", 32'(BUSY), 32'd0);
    check_eq("t5_async_wcnt", 32'(WCNT), 32'd0);
    exp_q.delete();
    wcnt_exp   = 0;
    prev_stall = 1'b0;
    @(posedge CLK);
    #1;
    RST_X = 1'b1;
    fifo_q.push_back(32'h0000BEEF);
    acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) cycle(1'b1);
    check_eq("t5_bytes", 32'(acc_cnt - acc0), 32'd4);
    check_eq("t5_wcnt", 32'(WCNT), 32'd1);

    // Random stream of five words, random BREADY, FIFO depth 5.
    do_reset();
    acc0   = acc_cnt;
    pushed = 0;
    done   = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (pushed < 5 && fifo_q.size() < 5 && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back($urandom);
        pushed++;
      end
      cycle($urandom_range(0, 3) != 0);
      done = (pushed == 5) && (fifo_q.size() == 0) && (exp_q.size() == 0) && !s_busy;
    end
    check_eq("t6_finished", 32'(done), 32'd1);
    check_eq("t6_bytes", 32'(acc_cnt - acc0), 32'd20);
    check_eq("t6_wcnt", 32'(WCNT), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
